conv_cache_wrt_ctrl: RTL and testbench

CONV_CACHE_WRT_CTRL -- requirements
Module: conv_cache_wrt_ctrl

---
 rtl/conv_cache_wrt_ctrl_if.sv | 56 +++++
 rtl/conv_cache_wrt_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_conv_cache_wrt_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_cache_wrt_ctrl_if.sv
// ----------------------------------------------------------------------------
// conv_cache_wrt_ctrl_if
// Purpose : bundles the pixel stream, frame control, cache port-A write bus
//           and consumer hand-off signals of the convolution cache write
//           controller.
// Modports:
//   master - the controller: consumes the pixel stream and frame control,
//            drives the cache write port and the block hand-off signals.
//   slave  - the environment: drives pixels/frame control/consume-done and
//            observes the cache write port and hand-off signals.
// Signals :
//   start_in, row_len_in                      frame start and line length
//   pixel_data_in/valid_in/last_in            input pixel stream
//   pixel_ready_out                           stream back-pressure
//   cache_port_a_wrt_data/addr/sel/en_out     cache write port A
//   cache_blk_sel_out                         ping-pong half being written
//   blk_valid_out, blk_consume_done_in        block hand-off
//   busy_out                                  controller not idle
// ----------------------------------------------------------------------------
interface conv_cache_wrt_ctrl_if #(
  parameter int DATA_WIDTH          = 16,
  parameter int IM_CACHE_DEPTH      = 512,
  parameter int IM_CACHE_COUNT      = 4,
  parameter int IM_CACHE_ADDR_WIDTH = $clog2(IM_CACHE_DEPTH)
);
  logic                             start_in;
  logic [IM_CACHE_ADDR_WIDTH:0]     row_len_in;
  logic [DATA_WIDTH-1:0]            pixel_data_in;
  logic                             pixel_valid_in;
  logic                             pixel_last_in;
  logic                             pixel_ready_out;
  logic [DATA_WIDTH-1:0]            cache_port_a_wrt_data_out;
  logic [IM_CACHE_ADDR_WIDTH-1:0]   cache_port_a_wrt_addr_out;
  logic [IM_CACHE_COUNT-1:0]        cache_port_a_wrt_sel_out;
  logic                             cache_port_a_wrt_en_out;
  logic                             cache_blk_sel_out;
  logic                             blk_valid_out;
  logic                             blk_consume_done_in;
  logic                             busy_out;

  modport master (
    input  start_in, row_len_in, pixel_data_in, pixel_valid_in, pixel_last_in,
    input  blk_consume_done_in,
    output pixel_ready_out, cache_port_a_wrt_data_out, cache_port_a_wrt_addr_out,
    output cache_port_a_wrt_sel_out, cache_port_a_wrt_en_out, cache_blk_sel_out,
    output blk_valid_out, busy_out
  );

  modport slave (
    output start_in, row_len_in, pixel_data_in, pixel_valid_in, pixel_last_in,
    output blk_consume_done_in,
    input  pixel_ready_out, cache_port_a_wrt_data_out, cache_port_a_wrt_addr_out,
    input  cache_port_a_wrt_sel_out, cache_port_a_wrt_en_out, cache_blk_sel_out,
    input  blk_valid_out, busy_out
  );
endinterface

// File: rtl/conv_cache_wrt_ctrl.sv
// ----------------------------------------------------------------------------
// conv_cache_wrt_ctrl
// Purpose : writes an incoming pixel stream into a ping-pong image cache made
//           of IM_CACHE_COUNT lines of row_len words. When one half is full it
//           is handed to the consumer (blk_valid_out) and writing continues in
//           the other half, stalling in WAIT_SWAP if the consumer still owns
//           the previously handed-off half.
// Ports   :
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - conv_cache_wrt_ctrl_if.master (pixel stream, frame control,
//           cache port-A write bus, block hand-off, busy)
// Option  : define CONV_CACHE_WRT_LAST_FLUSH_EN to let a beat carrying
//           pixel_last_in close the block early and return to IDLE after the
//           swap. Undefined (default) ignores pixel_last_in.
// Note    : IM_CACHE_COUNT must be at least 2.
// ----------------------------------------------------------------------------
module conv_cache_wrt_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int IM_CACHE_DEPTH = 512,
  parameter int IM_CACHE_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_cache_wrt_ctrl_if.master bus
);

  localparam int AW = $clog2(IM_CACHE_DEPTH);
  localparam logic [AW:0] ROW_MAX = (AW+1)'(IM_CACHE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FILL      = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_t;

  // Advance the one-hot line select to the next cache line, wrapping around.
  function automatic logic [IM_CACHE_COUNT-1:0] rotl1(input logic [IM_CACHE_COUNT-1:0] v);
    return {v[IM_CACHE_COUNT-2:0], v[IM_CACHE_COUNT-1]};
  endfunction

  state_t                    r_state;
  state_t                    w_next_state;
  logic [AW:0]               r_row_len;
  logic [AW-1:0]             r_addr;
  logic [IM_CACHE_COUNT-1:0] r_line_sel;
  logic                      r_owned;
  logic                      r_flush_pend;
  logic                      r_ready;
  logic                      r_busy;
  logic                      r_blk_sel;
  logic                      r_blk_valid;
  logic [DATA_WIDTH-1:0]     r_wrt_data;
  logic [AW-1:0]             r_wrt_addr;
  logic [IM_CACHE_COUNT-1:0] r_wrt_sel;
  logic                      r_wrt_en;

  logic                      w_accept;
  logic                      w_line_end;
  logic                      w_blk_full;
  logic                      w_last_close;
  logic                      w_close;
  logic                      w_swap;
  logic                      w_start;
  logic [AW:0]               w_row_len_clamped;

  assign w_accept          = bus.pixel_valid_in && r_ready;
  assign w_line_end        = ({1'b0, r_addr} == (r_row_len - (AW+1)'(1)));
  assign w_blk_full        = w_accept && r_line_sel[IM_CACHE_COUNT-1] && w_line_end;
  assign w_row_len_clamped = (bus.row_len_in > ROW_MAX) ? ROW_MAX : bus.row_len_in;

`ifdef CONV_CACHE_WRT_LAST_FLUSH_EN
  assign w_last_close = w_accept && bus.pixel_last_in;
`else
  assign w_last_close = 1'b0;
`endif

  assign w_close = w_blk_full || w_last_close;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the start and swap strobes.
  always_comb begin
    w_next_state = r_state;
    w_swap       = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_in && (bus.row_len_in != (AW+1)'(0))) begin
          w_start      = 1'b1;
          w_next_state = S_FILL;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FILL: begin
        if (w_close) begin
          // A done pulse in the same cycle releases the other half in time.
          if (!r_owned || bus.blk_consume_done_in) begin
            w_swap       = 1'b1;
            w_next_state = w_last_close ? S_IDLE : S_FILL;
          end else begin
            w_next_state = S_WAIT_SWAP;
          end
        end else begin
          w_next_state = S_FILL;
        end
      end
      S_WAIT_SWAP: begin
        if (bus.blk_consume_done_in) begin
          w_swap       = 1'b1;
          w_next_state = r_flush_pend ? S_IDLE : S_FILL;
        end else begin
          w_next_state = S_WAIT_SWAP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Line length latch plus the address / line-select write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_len  <= (AW+1)'(0);
      r_addr     <= AW'(0);
      r_line_sel <= IM_CACHE_COUNT'(0);
    end else if (w_start) begin
      r_row_len  <= w_row_len_clamped;
      r_addr     <= AW'(0);
      r_line_sel <= IM_CACHE_COUNT'(1);
    end else if (w_swap) begin
      r_addr     <= AW'(0);
      r_line_sel <= IM_CACHE_COUNT'(1);
    end else if (w_accept) begin
      if (w_line_end) begin
        r_addr     <= AW'(0);
        r_line_sel <= rotl1(r_line_sel);
      end else begin
        r_addr     <= r_addr + AW'(1);
      end
    end
  end

  // Consumer ownership flag and pending early-close marker for WAIT_SWAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owned      <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      // A swap hands a fresh half over, so it wins over a concurrent release.
      if (w_swap) begin
        r_owned <= 1'b1;
      end else if (bus.blk_consume_done_in) begin
        r_owned <= 1'b0;
      end
      if (w_swap || w_start) begin
        r_flush_pend <= 1'b0;
      end else if ((r_state == S_FILL) && (w_next_state == S_WAIT_SWAP)) begin
        r_flush_pend <= w_last_close;
      end
    end
  end

  // Registered cache port-A write: an accepted beat appears one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrt_data <= DATA_WIDTH'(0);
      r_wrt_addr <= AW'(0);
      r_wrt_sel  <= IM_CACHE_COUNT'(0);
      r_wrt_en   <= 1'b0;
    end else begin
      r_wrt_en <= w_accept;
      if (w_accept) begin
        r_wrt_data <= bus.pixel_data_in;
        r_wrt_addr <= r_addr;
        r_wrt_sel  <= r_line_sel;
      end
    end
  end

  // Registered handshake outputs, timed to track the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_blk_sel   <= 1'b0;
      r_blk_valid <= 1'b0;
    end else begin
      r_ready     <= (w_next_state == S_FILL);
      r_busy      <= (w_next_state != S_IDLE);
      r_blk_valid <= w_swap;
      if (w_swap) begin
        r_blk_sel <= ~r_blk_sel;
      end
    end
  end

  assign bus.pixel_ready_out           = r_ready;
  assign bus.busy_out                  = r_busy;
  assign bus.cache_blk_sel_out         = r_blk_sel;
  assign bus.blk_valid_out             = r_blk_valid;
  assign bus.cache_port_a_wrt_data_out = r_wrt_data;
  assign bus.cache_port_a_wrt_addr_out = r_wrt_addr;
  assign bus.cache_port_a_wrt_sel_out  = r_wrt_sel;
  assign bus.cache_port_a_wrt_en_out   = r_wrt_en;

endmodule

// File: tb/tb_conv_cache_wrt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_conv_cache_wrt_ctrl
// Directed bench for conv_cache_wrt_ctrl (DATA_WIDTH=16, IM_CACHE_DEPTH=512,
// IM_CACHE_COUNT=4). Inputs change 1 time unit after a rising edge and
// outputs are sampled there, so each check sees the effect of that edge.
// ----------------------------------------------------------------------------
module tb_conv_cache_wrt_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  conv_cache_wrt_ctrl_if #(
    .DATA_WIDTH(16), .IM_CACHE_DEPTH(512), .IM_CACHE_COUNT(4)
  ) bus_if ();

  conv_cache_wrt_ctrl #(
    .DATA_WIDTH(16), .IM_CACHE_DEPTH(512), .IM_CACHE_COUNT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input int addr, input int sel,
                        input int data);
    chk({tag, ".en"}, 32'(bus_if.cache_port_a_wrt_en_out), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(bus_if.cache_port_a_wrt_addr_out), 32'(addr));
      chk({tag, ".sel"},  32'(bus_if.cache_port_a_wrt_sel_out),  32'(sel));
      chk({tag, ".data"}, 32'(bus_if.cache_port_a_wrt_data_out), 32'(data));
    end
  endtask

  task automatic chk_hs(input string tag, input logic rdy, input logic busy,
                        input logic bsel, input logic bval);
    chk({tag, ".ready"},     32'(bus_if.pixel_ready_out),   32'(rdy));
    chk({tag, ".busy"},      32'(bus_if.busy_out),          32'(busy));
    chk({tag, ".blk_sel"},   32'(bus_if.cache_blk_sel_out), 32'(bsel));
    chk({tag, ".blk_valid"}, 32'(bus_if.blk_valid_out),     32'(bval));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"},   32'(bus_if.cache_port_a_wrt_en_out),   32'd0);
    chk({tag, ".addr"}, 32'(bus_if.cache_port_a_wrt_addr_out), 32'd0);
    chk({tag, ".sel"},  32'(bus_if.cache_port_a_wrt_sel_out),  32'd0);
    chk({tag, ".data"}, 32'(bus_if.cache_port_a_wrt_data_out), 32'd0);
    chk_hs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input int len);
    bus_if.start_in   = 1'b1;
    bus_if.row_len_in = 10'(len);
    tick();
    bus_if.start_in   = 1'b0;
  endtask

  task automatic beat(input int data, input logic last, input logic done);
    bus_if.pixel_valid_in      = 1'b1;
    bus_if.pixel_data_in       = 16'(data);
    bus_if.pixel_last_in       = last;
    bus_if.blk_consume_done_in = done;
    tick();
    bus_if.pixel_valid_in      = 1'b0;
    bus_if.pixel_last_in       = 1'b0;
    bus_if.blk_consume_done_in = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus_if.start_in            = 1'b0;
    bus_if.row_len_in          = 10'd0;
    bus_if.pixel_data_in       = 16'd0;
    bus_if.pixel_valid_in      = 1'b0;
    bus_if.pixel_last_in       = 1'b0;
    bus_if.blk_consume_done_in = 1'b0;

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Block 1: row_len=3, 12 back-to-back beats, free consumer -> swap 0->1
    start(3);
    chk_hs("b1_start", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      beat(16'h100 + i, 1'b0, 1'b0);
      chk_wr($sformatf("b1_w%0d", i), 1'b1, i % 3, 1 << (i / 3), 16'h100 + i);
      chk_hs($sformatf("b1_w%0d", i), 1'b1, 1'b1, (i == 11), (i == 11));
    end
    tick();
    chk_wr("b1_idle", 1'b0, 0, 0, 0);
    chk_hs("b1_idle", 1'b1, 1'b1, 1'b1, 1'b0);

    // Block 2: consumer still owns block 1 -> WAIT_SWAP until done pulse
    for (int i = 0; i < 12; i++) begin
      beat(16'h200 + i, 1'b0, 1'b0);
      chk_wr($sformatf("b2_w%0d", i), 1'b1, i % 3, 1 << (i / 3), 16'h200 + i);
      chk_hs($sformatf("b2_w%0d", i), (i != 11), 1'b1, 1'b1, 1'b0);
    end
    bus_if.pixel_valid_in = 1'b1;
    tick();
    chk_wr("b2_wait0", 1'b0, 0, 0, 0);
    chk_hs("b2_wait0", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_wr("b2_wait1", 1'b0, 0, 0, 0);
    chk_hs("b2_wait1", 1'b0, 1'b1, 1'b1, 1'b0);
    bus_if.pixel_valid_in      = 1'b0;
    bus_if.blk_consume_done_in = 1'b1;
    tick();
    bus_if.blk_consume_done_in = 1'b0;
    chk_hs("b2_swap", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_hs("b2_after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Block 3: done coincident with the full beat -> immediate swap
    for (int i = 0; i < 12; i++) begin
      beat(16'h300 + i, 1'b0, (i == 11));
      chk_wr($sformatf("b3_w%0d", i), 1'b1, i % 3, 1 << (i / 3), 16'h300 + i);
      chk_hs($sformatf("b3_w%0d", i), 1'b1, 1'b1, (i == 11), (i == 11));
    end
    tick();
    chk_hs("b3_after", 1'b1, 1'b1, 1'b1, 1'b0);

    // Row length clamp (1023 -> 512); start during FILL is ignored
    do_reset();
    start(1023);
    bus_if.start_in   = 1'b1;
    bus_if.row_len_in = 10'd2;
    beat(16'h0, 1'b0, 1'b0);
    bus_if.start_in   = 1'b0;
    chk_wr("clamp_w0", 1'b1, 0, 1, 0);
    for (int i = 1; i < 513; i++) begin
      beat(i, 1'b0, 1'b0);
      if (i >= 511) begin
        chk_wr($sformatf("clamp_w%0d", i), 1'b1, i % 512, 1 << (i / 512), i);
      end
    end

    // Zero row length start is ignored
    do_reset();
    start(0);
    chk_hs("len0", 1'b0, 1'b0, 1'b0, 1'b0);

    // pixel_last on beat 5 of row_len=3
    start(3);
    for (int i = 0; i < 5; i++) begin
      beat(16'h500 + i, (i == 4), 1'b0);
      chk_wr($sformatf("last_w%0d", i), 1'b1, i % 3, 1 << (i / 3), 16'h500 + i);
    end
`ifdef CONV_CACHE_WRT_LAST_FLUSH_EN
    chk_hs("last_swap", 1'b0, 1'b0, 1'b1, 1'b1);
    beat(16'h5ff, 1'b0, 1'b0);
    chk_wr("last_idle", 1'b0, 0, 0, 0);
    chk_hs("last_idle", 1'b0, 1'b0, 1'b1, 1'b0);
`else
    chk_hs("last_noswap", 1'b1, 1'b1, 1'b0, 1'b0);
    beat(16'h505, 1'b0, 1'b0);
    chk_wr("last_cont", 1'b1, 2, 2, 16'h505);
    chk_hs("last_cont", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Reset after 7 beats aborts the fill; restart begins at addr 0 sel 1
    do_reset();
    start(3);
    for (int i = 0; i < 7; i++) begin
      beat(16'h700 + i, 1'b0, 1'b0);
    end
    chk_wr("rst_pre", 1'b1, 0, 4, 16'h706);
    bus_if.pixel_valid_in = 1'b1;
    bus_if.pixel_data_in  = 16'h7aa;
    reset = 1'b1;
    tick();
    chk_all_zero("rst_mid0");
    tick();
    chk_all_zero("rst_mid1");
    reset = 1'b0;
    bus_if.pixel_valid_in = 1'b0;
    start(3);
    beat(16'h7bb, 1'b0, 1'b0);
    chk_wr("rst_restart", 1'b1, 0, 1, 16'h7bb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
